// File: rtl/adder_ripple_4bit_core_if.sv
// Operand/result bundle for the 4-bit ripple-carry adder.
interface adder_ripple_4bit_core_if;
    localparam int unsigned WIDTH = 4;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    // Operand source drives a/b/cin and observes the result
    modport master (
        output a, b, cin,
        input  sum, cout, ovf, zero
    );

    // Adder consumes operands and drives the result
    modport slave (
        input  a, b, cin,
        output sum, cout, ovf, zero
    );
endinterface

// File: rtl/adder_ripple_4bit_core.sv
// 4-bit ripple-carry adder (SAP ALU add path) with optional output register.
module adder_ripple_4bit_core #(
    parameter bit REG_OUT = 1'b1
) (
    input logic                      clk,
    input logic                      rst,
    adder_ripple_4bit_core_if.slave  bus
);
    localparam int unsigned WIDTH = 4;

    logic [WIDTH:0]   carry_c;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
    logic             ovf_c;
    logic             zero_c;

    // Chain of full-adder stages; carry moves strictly from bit 0 upward
    always_comb begin
        carry_c    = '0;
        sum_c      = '0;
        carry_c[0] = bus.cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum_c[i]     = bus.a[i] ^ bus.b[i] ^ carry_c[i];
            carry_c[i+1] = (bus.a[i] & bus.b[i]) | (carry_c[i] & (bus.a[i] ^ bus.b[i]));
        end
    end

    // Flags: unsigned carry-out, signed overflow (carry into MSB vs out of MSB), zero sum
    always_comb begin
        cout_c = carry_c[WIDTH];
        ovf_c  = carry_c[WIDTH-1] ^ carry_c[WIDTH];
        zero_c = (sum_c == WIDTH'(0));
    end

    generate
        if (REG_OUT) begin : g_reg
            // One-cycle result register; reset clears any pending result
            always_ff @(posedge clk) begin
                if (rst) begin
                    bus.sum  <= '0;
                    bus.cout <= 1'b0;
                    bus.ovf  <= 1'b0;
                    bus.zero <= 1'b1;
                end else begin
                    bus.sum  <= sum_c;
                    bus.cout <= cout_c;
                    bus.ovf  <= ovf_c;
                    bus.zero <= zero_c;
                end
            end
        end else begin : g_comb
            // Pass-through: outputs track operands, clk/rst play no part
            assign bus.sum  = sum_c;
            assign bus.cout = cout_c;
            assign bus.ovf  = ovf_c;
            assign bus.zero = zero_c;
        end
    endgenerate
endmodule

// File: tb/tb_adder_ripple_4bit_core.sv
// Self-checking bench for adder_ripple_4bit_core (registered and combinational builds).
module tb_adder_ripple_4bit_core;
    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic rst_c;
    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    adder_ripple_4bit_core_if bus ();
    adder_ripple_4bit_core_if bus_c ();

    adder_ripple_4bit_core #(.REG_OUT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    adder_ripple_4bit_core #(.REG_OUT(1'b0)) dut_c (
        .clk (clk),
        .rst (rst_c),
        .bus (bus_c.slave)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
        logic [4:0] t;
        res_t r;
        t      = 5'(ma) + 5'(mb) + 5'(mc);
        r.sum  = t[3:0];
        r.cout = t[4];
        r.ovf  = (ma[3] == mb[3]) && (t[3] != ma[3]);
        r.zero = (t[3:0] == 4'h0);
        return r;
    endfunction

    // Apply operands to the registered DUT and queue the expected result
    task automatic drive(input logic [3:0] oa, input logic [3:0] ob, input logic oc);
        bus.a   = oa;
        bus.b   = ob;
        bus.cin = oc;
        sb.push_back(model(oa, ob, oc));
    endtask

    task automatic test_reset();
        res_t obs;
        rst = 1'b1;
        bus.a = 4'h5; bus.b = 4'h5; bus.cin = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            obs = {bus.sum, bus.cout, bus.ovf, bus.zero};
            checks++;
            if (obs !== {4'h0, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset_hold: got %h want %h", obs, {4'h0, 1'b0, 1'b0, 1'b1});
            end
        end
        rst = 1'b0;
        bus.b = 4'h0;
        @(posedge clk); #1;
        checks++;
        if (bus.sum !== 4'h5 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: sum=%h zero=%b want sum=5 zero=0", bus.sum, bus.zero);
        end
    endtask

    task automatic test_directed();
        logic [3:0] va[4];
        logic [3:0] vb[4];
        logic       vc[4];
        res_t       want[4];
        res_t       exp, obs;
        va = '{4'hf, 4'h0, 4'h1, 4'h7};
        vb = '{4'h0, 4'hf, 4'h1, 4'h1};
        vc = '{1'b0, 1'b1, 1'b1, 1'b0};
        want = '{{4'hf, 1'b0, 1'b0, 1'b0},
                 {4'h0, 1'b1, 1'b0, 1'b1},
                 {4'h3, 1'b0, 1'b0, 1'b0},
                 {4'h8, 1'b0, 1'b1, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            drive(va[i], vb[i], vc[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            obs = {bus.sum, bus.cout, bus.ovf, bus.zero};
            checks++;
            if (obs !== want[i] || obs !== exp) begin
                errors++;
                $display("FAIL directed_%0d: got %h want %h", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_wrap();
        res_t exp, obs;
        drive(4'hf, 4'hf, 1'b1);
        @(posedge clk); #1;
        exp = sb.pop_front();
        obs = {bus.sum, bus.cout, bus.ovf, bus.zero};
        checks++;
        if (obs !== {4'hf, 1'b1, 1'b0, 1'b0} || obs !== exp) begin
            errors++;
            $display("FAIL wrap: got %h want %h", obs, {4'hf, 1'b1, 1'b0, 1'b0});
        end
    endtask

    // Operands change every cycle; each result is checked one edge later
    task automatic test_exhaustive();
        res_t exp, obs;
        for (int k = 0; k < 512; k++) begin
            drive(4'(k >> 5), 4'(k >> 1), k[0]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            obs = {bus.sum, bus.cout, bus.ovf, bus.zero};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL sweep_%0d: a=%h b=%h cin=%b got %h want %h",
                         k, bus.a, bus.b, bus.cin, obs, exp);
            end
        end
    endtask

    task automatic test_reset_midstream();
        res_t exp, obs;
        drive(4'h3, 4'h4, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        void'(sb.pop_front());
        obs = {bus.sum, bus.cout, bus.ovf, bus.zero};
        checks++;
        if (obs !== {4'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_midstream: got %h want %h", obs, {4'h0, 1'b0, 1'b0, 1'b1});
        end
        rst = 1'b0;
        drive(4'h9, 4'h9, 1'b1);
        @(posedge clk); #1;
        exp = sb.pop_front();
        obs = {bus.sum, bus.cout, bus.ovf, bus.zero};
        checks++;
        if (obs !== exp || obs !== {4'h3, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL after_midstream: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_comb();
        res_t exp, obs;
        bus_c.a = 4'hf; bus_c.b = 4'h0; bus_c.cin = 1'b0;
        rst_c = 1'b0;
        #1;
        checks++;
        if (bus_c.sum !== 4'hf || bus_c.cout !== 1'b0 || bus_c.zero !== 1'b0) begin
            errors++;
            $display("FAIL comb_same_step: sum=%h cout=%b want sum=f cout=0", bus_c.sum, bus_c.cout);
        end
        rst_c = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus_c.sum !== 4'hf || bus_c.zero !== 1'b0) begin
            errors++;
            $display("FAIL comb_rst_ignored: sum=%h want f", bus_c.sum);
        end
        for (int i = 0; i < 16; i++) begin
            bus_c.a   = 4'($urandom_range(15));
            bus_c.b   = 4'($urandom_range(15));
            bus_c.cin = 1'($urandom_range(1));
            rst_c     = ~rst_c;
            #1;
            exp = model(bus_c.a, bus_c.b, bus_c.cin);
            obs = {bus_c.sum, bus_c.cout, bus_c.ovf, bus_c.zero};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL comb_rand_%0d: got %h want %h", i, obs, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rst_c = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        bus_c.a = '0; bus_c.b = '0; bus_c.cin = 1'b0;
        test_reset();
        test_directed();
        test_wrap();
        test_exhaustive();
        test_reset_midstream();
        test_comb();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
